op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Command-queue front end for the matrix engine controller.
- Accepts 32-bit operation words from the host and issues each one to the controller's operation input for exactly the required number of cycles.
- Throttles the serial page-write stream with a valid/ready handshake and frames the serial page-read stream with a valid flag.
- Inserts a one-cycle idle gap between commands, so the controller always sees a fresh rising edge of a matmul opcode.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- PAGE_WORDS, 64, words moved by one serial write (opcode 2) or serial read (opcode 3).
- MM_DRAIN, 24, extra cycles opcode 1 is held after memory shifting ends, to drain the multiplier pipeline and write back results.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  32  operation word; bits [3:0] are the opcode
- size_cfg  in  9  matrix size configuration; [5:0] is cells-1, [8:6] is lines-1
- din_valid  in  1  serial write data valid
- din_ready  out  1  sequencer accepts din_data this cycle
- din_data  in  32  serial write data
- ctrl_operation  out  32  to controller operation input
- ctrl_enable  out  1  to controller enable input
- ctrl_in_data  out  32  to controller in_data input
- ctrl_out_data  in  32  from controller out_data output
- dout_valid  out  1  dout_data holds a read word
- dout_data  out  32  serial read data
- busy  out  1  FIFO non-empty or state not IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: ctrl_operation=0, ctrl_enable=1, dout_valid=0, done=0, err=0, din_ready=0. FIFO is emptied and state goes to IDLE. Reset mid-command aborts the command immediately; there is no done pulse.
- FIFO: push when cmd_valid && cmd_ready. cmd_ready = !full; a pop in the same cycle does not raise cmd_ready. Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- IDLE: if FIFO non-empty, pop the head and latch it as cur_op. Latch size_cfg as cur_size. Decode the opcode:
  - 0 -> GAP (no-op, done pulses)
  - 1 -> MM
  - 2 -> WR
  - 3 -> RD
  - 4-15 -> set err, discard the command, stay in IDLE. There is no done pulse and the next command can be popped the following cycle.
  - While in IDLE, ctrl_operation=0.
- MM:
  - ctrl_operation=cur_op and ctrl_enable=1 for exactly L cycles, then go to GAP.
  - L = (cur_size[5:0]+1)*(cur_size[8:6]+1)^2 + MM_DRAIN.
  - Use a 16-bit down-counter loaded with L-1; MM exits when it reaches 0.
- WR:
  - ctrl_operation=cur_op, din_ready=1, ctrl_enable=din_valid, ctrl_in_data=din_data (combinational pass-through).
  - The word counter increments on din_valid. Stall cycles (din_valid=0) freeze the controller and the counter.
  - After PAGE_WORDS accepted words, go to GAP. din_ready=0 in every state other than WR.
- RD:
  - ctrl_operation=cur_op, ctrl_enable=1 for exactly PAGE_WORDS cycles, then go to GAP.
  - The controller's output lags by one cycle, so dout_valid is the RD-active flag registered one cycle. dout_data=ctrl_out_data.
  - The last word is presented during the GAP cycle. dout has no backpressure; the consumer must sink one word per valid cycle.
- GAP: exactly one cycle with ctrl_operation=0 and ctrl_enable=1; done=1 in this cycle; next state is IDLE.
- Issue rate: minimum command-to-command issue spacing is L+2 cycles (exec, GAP, IDLE pop).
- ctrl_enable=1 in every state except WR.
- Counters: all counters reset to 0 on entry to each exec state. Arithmetic is unsigned with no overflow; the maximum L is 64*64+MM_DRAIN, which fits in 16 bits.
- Pushes during execution are accepted while the FIFO is not full. cmd_op bits [31:4] are passed through unmodified.

Test Plan:
- Matmul timing: reset, size_cfg=9'b001_000111, push cmd_op=32'h00_0_0_8_4_0_1 -> ctrl_operation equals the word for exactly 56 consecutive cycles (8*2*2+24). Then one cycle of 0 with done=1, then busy=0.
- Write with stalls: push opcode 2 to page 0, drive 64 words with din_valid low on every 4th cycle -> ctrl_enable tracks din_valid, 64 words are forwarded in order, and done pulses one cycle after the 64th accepted word.
- Read framing: a controller model returns out_data = index delayed one cycle, push opcode 3 -> dout_valid is high for 64 cycles starting one cycle after issue, dout_data is 0..63, and the final word appears during the GAP cycle.
- FIFO full: with DEPTH=4, push 5 matmul commands back-to-back while the first executes -> cmd_ready=0 when 4 entries are held. All commands issue in order, each separated by a single opcode-0 cycle, with 5 done pulses.
- Illegal opcode: push 32'h0000_0007 then a 1-cycle no-op (opcode 0) -> err goes high and stays high, opcode 7 never appears on ctrl_operation, and exactly one done pulse occurs.
- Reset mid-matmul: assert reset at cycle 20 of the 56-cycle command with 2 commands queued -> the next cycle has ctrl_operation=0, busy=0, cmd_ready=1, and no done pulse.

Source files
------------

// File: rtl/op_sequencer.sv
// Command-queue front end for the matrix engine controller: buffers host operation words,
// holds each on ctrl_operation for its exact duration and follows it with a one-cycle idle gap.
module op_sequencer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PAGE_WORDS = 64,
    parameter int unsigned MM_DRAIN   = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_op,
    input  logic [8:0]  size_cfg,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic [31:0] ctrl_operation,
    output logic        ctrl_enable,
    output logic [31:0] ctrl_in_data,
    input  logic [31:0] ctrl_out_data,
    output logic        dout_valid,
    output logic [31:0] dout_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] PAGE_LAST = CW'(PAGE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MM,
        S_WR,
        S_RD,
        S_GAP
    } state_t;

    state_t        state;
    logic [31:0]   cur_op;
    logic [CW-1:0] cnt;

    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    logic [6:0]    cells;
    logic [3:0]    lines;
    logic [CW-1:0] mm_len;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr];

    // Command FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_op;
        end
    end

    // Matmul hold time: cells * lines^2 shift cycles plus the pipeline drain.
    always_comb begin
        cells  = 7'(size_cfg[5:0]) + 7'd1;
        lines  = 4'(size_cfg[8:6]) + 4'd1;
        mm_len = CW'(cells) * CW'(lines) * CW'(lines) + CW'(MM_DRAIN);
    end

    // Issue sequencer; size_cfg is consumed at pop time via the matmul down-counter load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_op     <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= (state == S_RD);
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur_op <= head;
                        cnt    <= '0;
                        case (head[3:0])
                            4'd0: state <= S_GAP;
                            4'd1: begin
                                state <= S_MM;
                                cnt   <= mm_len - CW'(1);
                            end
                            4'd2: state <= S_WR;
                            4'd3: state <= S_RD;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_MM: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WR: begin
                    if (din_valid) begin
                        if (cnt == PAGE_LAST) begin
                            state <= S_GAP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_RD: begin
                    if (cnt == PAGE_LAST) begin
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Controller-facing decode of the registered state; write data passes straight through.
    always_comb begin
        ctrl_operation = '0;
        ctrl_enable    = 1'b1;
        din_ready      = 1'b0;
        unique case (state)
            S_MM, S_RD: ctrl_operation = cur_op;
            S_WR: begin
                ctrl_operation = cur_op;
                ctrl_enable    = din_valid;
                din_ready      = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl_in_data = din_data;
    assign dout_data    = ctrl_out_data;
    assign busy         = !empty || (state != S_IDLE);
    assign done         = (state == S_GAP);

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: table of matmul/no-op vectors plus directed write, read,
// FIFO-full, illegal-opcode and mid-command reset sequences.
module tb_op_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_op = '0;
    logic [8:0]  size_cfg = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] din_data = '0;
    logic [31:0] ctrl_operation;
    logic        ctrl_enable;
    logic [31:0] ctrl_in_data;
    logic [31:0] ctrl_out_data;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    op_sequencer #(.DEPTH(4), .PAGE_WORDS(64), .MM_DRAIN(24)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .size_cfg(size_cfg),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .ctrl_operation(ctrl_operation), .ctrl_enable(ctrl_enable),
        .ctrl_in_data(ctrl_in_data), .ctrl_out_data(ctrl_out_data),
        .dout_valid(dout_valid), .dout_data(dout_data),
        .busy(busy), .done(done), .err(err)
    );

    // Controller model: each enabled read cycle returns its word index one cycle later.
    logic [31:0] model_idx;
    always @(posedge clk) begin
        if (reset) begin
            model_idx     <= '0;
            ctrl_out_data <= '0;
        end else if (ctrl_operation[3:0] == 4'd3 && ctrl_enable) begin
            ctrl_out_data <= model_idx;
            model_idx     <= model_idx + 32'd1;
        end
    end

    // Background monitor: done pulses, runs of non-zero ctrl_operation, err stickiness.
    logic        mon_en = 1'b0;
    logic        mon_clr = 1'b0;
    logic        mon_in_run;
    logic        mon_err_seen;
    int          mon_done, mon_nz, mon_runs, mon_cyc, mon_err_drop;
    logic [31:0] run_op [8];
    int          run_start [8];
    int          run_len [8];

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_done = 0; mon_nz = 0; mon_runs = 0; mon_cyc = 0; mon_err_drop = 0;
            mon_in_run = 1'b0; mon_err_seen = 1'b0;
        end else if (mon_en) begin
            mon_cyc++;
            if (done) mon_done++;
            if (err) mon_err_seen = 1'b1;
            else if (mon_err_seen) mon_err_drop++;
            if (ctrl_operation != 32'd0) begin
                mon_nz++;
                if (!mon_in_run) begin
                    mon_in_run = 1'b1;
                    if (mon_runs < 8) begin
                        run_op[mon_runs]    = ctrl_operation;
                        run_start[mon_runs] = mon_cyc;
                        run_len[mon_runs]   = 0;
                    end
                end
                if (mon_runs < 8) run_len[mon_runs]++;
            end else if (mon_in_run) begin
                mon_in_run = 1'b0;
                mon_runs++;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; din_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic mon_start();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        mon_en  = 1'b1;
    endtask

    typedef struct {
        logic [31:0] op;
        logic [8:0]  size;
        int          len;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t, nz, bad, done_t, c, words, acc_last, e_rdy, e_en, e_dat, vcnt, first_v, rd_cyc, w, mm;
        logic [31:0] done_dout;
        logic        done_dv;
        logic [31:0] fops [5];
        logic [31:0] rops [3];

        vecs[0] = '{32'h0000_8401, 9'b001_000111, 56};
        vecs[1] = '{32'hDEAD_BEE1, 9'b000_000000, 25};
        vecs[2] = '{32'h0000_0021, 9'b010_000011, 60};
        vecs[3] = '{32'h1234_5671, 9'b111_111111, 4120};
        vecs[4] = '{32'h1230_0000, 9'b000_000000, 0};

        do_reset();
        chk("rst_ctrl_operation", ctrl_operation, 0);
        chk("rst_ctrl_enable", ctrl_enable, 1);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Table: hold length, done timing and op value for single commands.
        foreach (vecs[i]) begin
            cmd_valid = 1'b1; cmd_op = vecs[i].op; size_cfg = vecs[i].size;
            settle();
            tick();
            cmd_valid = 1'b0;
            t = 0; nz = 0; bad = 0; done_t = -1;
            while (t < 5000 && done_t < 0) begin
                settle();
                if (done) done_t = t;
                if (ctrl_operation != 32'd0) begin
                    nz++;
                    if (ctrl_operation != vecs[i].op) bad++;
                end
                tick();
                t++;
            end
            settle();
            chk($sformatf("vec%0d_hold_cycles", i), nz, vecs[i].len);
            chk($sformatf("vec%0d_done_cycle", i), done_t, vecs[i].len + 1);
            chk($sformatf("vec%0d_wrong_op", i), bad, 0);
            chk($sformatf("vec%0d_busy_after", i), busy, 0);
            chk($sformatf("vec%0d_done_after", i), done, 0);
        end

        // Serial write with din_valid low every 4th cycle.
        cmd_valid = 1'b1; cmd_op = 32'h0000_0002; din_valid = 1'b0;
        settle();
        tick();
        cmd_valid = 1'b0;
        c = 0; words = 0; acc_last = -1; done_t = -1; e_rdy = 0; e_en = 0; e_dat = 0;
        while (c < 600 && done_t < 0) begin
            din_valid = (c >= 1) && (c % 4 != 0);
            din_data  = 32'hA500_0000 + 32'(words);
            settle();
            if (din_ready !== ((c >= 1) && (words < 64))) e_rdy++;
            if (done) done_t = c;
            if (din_ready) begin
                if (ctrl_enable !== din_valid) e_en++;
                if (ctrl_operation !== 32'h0000_0002) e_en++;
                if (din_valid) begin
                    if (ctrl_in_data !== 32'hA500_0000 + 32'(words)) e_dat++;
                    words++;
                    acc_last = c;
                end
            end
            tick();
            c++;
        end
        din_valid = 1'b0;
        chk("wr_words", words, 64);
        chk("wr_ready_errors", e_rdy, 0);
        chk("wr_enable_errors", e_en, 0);
        chk("wr_data_errors", e_dat, 0);
        chk("wr_done_cycle", done_t, 86);

        // Serial read framing against the one-cycle-lag controller model.
        cmd_valid = 1'b1; cmd_op = 32'h0000_0503;
        settle();
        tick();
        cmd_valid = 1'b0;
        c = 0; vcnt = 0; first_v = -1; e_dat = 0; done_t = -1; rd_cyc = 0;
        done_dout = '0; done_dv = 1'b0;
        while (c < 300 && done_t < 0) begin
            settle();
            if (dout_valid) begin
                if (first_v < 0) first_v = c;
                if (dout_data !== 32'(vcnt)) e_dat++;
                vcnt++;
            end
            if (ctrl_operation == 32'h0000_0503) rd_cyc++;
            if (done) begin
                done_t = c; done_dout = dout_data; done_dv = dout_valid;
            end
            tick();
            c++;
        end
        settle();
        chk("rd_issue_cycles", rd_cyc, 64);
        chk("rd_first_valid", first_v, 2);
        chk("rd_valid_count", vcnt, 64);
        chk("rd_data_errors", e_dat, 0);
        chk("rd_done_cycle", done_t, 65);
        chk("rd_gap_valid", done_dv, 1);
        chk("rd_gap_word", done_dout, 63);
        chk("rd_valid_after", dout_valid, 0);

        // FIFO full: five back-to-back matmuls of 25 cycles each.
        size_cfg = 9'b000_000000;
        mon_start();
        for (int k = 0; k < 5; k++) begin
            fops[k] = 32'h0A00_0001 + 32'(k) * 32'h100;
            cmd_valid = 1'b1; cmd_op = fops[k];
            settle();
            w = 0;
            while (!cmd_ready && w < 100) begin
                tick(); settle(); w++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        settle();
        chk("fifo_full_ready", cmd_ready, 0);
        w = 0;
        while (mon_done < 5 && w < 400) begin
            tick(); w++;
        end
        tick(); tick();
        settle();
        chk("fifo_runs", mon_runs, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fifo_op%0d", k), run_op[k], fops[k]);
            chk($sformatf("fifo_len%0d", k), run_len[k], 25);
            if (k > 0) chk($sformatf("fifo_spacing%0d", k), run_start[k] - run_start[k-1], 27);
        end
        chk("fifo_done_pulses", mon_done, 5);
        chk("fifo_busy_after", busy, 0);

        // Illegal opcode followed by a no-op.
        do_reset();
        mon_start();
        cmd_valid = 1'b1; cmd_op = 32'h0000_0007;
        settle();
        tick();
        cmd_op = 32'h0000_0000;
        settle();
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        settle();
        chk("ill_err", err, 1);
        chk("ill_err_dropped", mon_err_drop, 0);
        chk("ill_nonzero_ops", mon_nz, 0);
        chk("ill_done_pulses", mon_done, 1);

        // Reset at cycle 20 of a 56-cycle matmul with two commands queued.
        do_reset();
        mon_en = 1'b0;
        size_cfg = 9'b001_000111;
        rops[0] = 32'h0000_8401; rops[1] = 32'h0000_9401; rops[2] = 32'h0000_A401;
        mm = 0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_op = rops[k];
            settle();
            if (ctrl_operation == rops[0]) mm++;
            tick();
        end
        cmd_valid = 1'b0;
        w = 0;
        while (w < 100) begin
            settle();
            if (ctrl_operation == rops[0]) mm++;
            if (mm >= 20) break;
            tick();
            w++;
        end
        chk("rstmid_reached_cycle20", mm, 20);
        reset = 1'b1;
        tick();
        settle();
        chk("rstmid_ctrl_operation", ctrl_operation, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        chk("rstmid_done", done, 0);
        reset = 1'b0;
        mon_start();
        for (int k = 0; k < 70; k++) tick();
        chk("rstmid_later_ops", mon_nz, 0);
        chk("rstmid_later_done", mon_done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
